// File: rtl/tri_bus_arbiter.sv
// tri_bus_arbiter: round-robin enable generator for a shared tri-state bus, with a turnaround gap between owners.
// Define ARB_TIMEOUT_EN to build the MAX_HOLD ownership limit with forced release and the oTimeout pulse.
module tri_bus_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned TURN_CYCLES = 1,
    parameter int unsigned MAX_HOLD    = 16
) (
    input  logic                     iClk,
    input  logic                     iRst_n,
    input  logic [N_REQ-1:0]         iReq,
    output logic [N_REQ-1:0]         oEna,
    output logic [$clog2(N_REQ)-1:0] oGntIdx,
    output logic                     oBusValid,
    output logic                     oBusy,
    output logic                     oTimeout
);
    localparam int unsigned IDX_W  = $clog2(N_REQ);
    localparam int unsigned SUM_W  = IDX_W + 1;
    localparam int unsigned TURN_W = 4;
    localparam int unsigned HOLD_W = 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_TURN  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [N_REQ-1:0]  ena_q, ena_d;
    logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
    logic              bus_valid_q, bus_valid_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [TURN_W-1:0] turn_cnt_q, turn_cnt_d;

    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  cand;
    logic [N_REQ-1:0]  cand_sh;
    logic [N_REQ-1:0]  owner_sh;
    logic              owner_req;
    logic              release_req;
    logic              turn_last;
    logic              arb_now;

    // (base + off) mod N_REQ, valid for any N_REQ since base, off < N_REQ
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input logic [SUM_W-1:0] off);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + off;
        if (sum >= SUM_W'(N_REQ)) sum = sum - SUM_W'(N_REQ);
        return IDX_W'(sum);
    endfunction

    // Lowest-offset requester at or after the rr pointer; loop runs downward so the nearest wins
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        cand_sh   = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            cand    = wrap_add(ptr_q, SUM_W'(i));
            cand_sh = iReq >> cand;
            if (cand_sh[0]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign owner_sh  = iReq >> gnt_idx_q;
    assign owner_req = owner_sh[0];
    assign turn_last = (turn_cnt_q == TURN_W'(TURN_CYCLES - 1));
    assign arb_now   = (state_q != S_GRANT) && ((state_q != S_TURN) || turn_last);

`ifdef ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              hold_expired;

    assign hold_expired = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
    assign release_req  = !owner_req || hold_expired;
`else
    logic unused_max_hold;

    assign unused_max_hold = ^HOLD_W'(MAX_HOLD);
    assign release_req     = !owner_req;
`endif

    always_comb begin
        state_d     = state_q;
        ena_d       = ena_q;
        gnt_idx_d   = gnt_idx_q;
        bus_valid_d = bus_valid_q;
        busy_d      = busy_q;
        timeout_d   = 1'b0;
        ptr_d       = ptr_q;
        turn_cnt_d  = turn_cnt_q;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d  = hold_cnt_q;
`endif
        case (state_q)
            S_GRANT: begin
`ifdef ARB_TIMEOUT_EN
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
`endif
                if (release_req) begin
                    state_d     = S_TURN;
                    ena_d       = '0;
                    bus_valid_d = 1'b0;
                    ptr_d       = wrap_add(gnt_idx_q, SUM_W'(1));
                    turn_cnt_d  = '0;
`ifdef ARB_TIMEOUT_EN
                    timeout_d   = owner_req && hold_expired;
`endif
                end
            end
            S_TURN: begin
                if (!turn_last) turn_cnt_d = turn_cnt_q + TURN_W'(1);
            end
            default: ;
        endcase

        // Shared arbitration point for IDLE and the final TURN cycle
        if (arb_now) begin
            if (win_found) begin
                state_d     = S_GRANT;
                ena_d       = N_REQ'(1) << win_idx;
                gnt_idx_d   = win_idx;
                bus_valid_d = 1'b1;
                busy_d      = 1'b1;
`ifdef ARB_TIMEOUT_EN
                hold_cnt_d  = '0;
`endif
            end else begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q     <= S_IDLE;
            ena_q       <= '0;
            gnt_idx_q   <= '0;
            bus_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            ptr_q       <= '0;
            turn_cnt_q  <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ena_q       <= ena_d;
            gnt_idx_q   <= gnt_idx_d;
            bus_valid_q <= bus_valid_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            ptr_q       <= ptr_d;
            turn_cnt_q  <= turn_cnt_d;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q  <= hold_cnt_d;
`endif
        end
    end

    assign oEna      = ena_q;
    assign oGntIdx   = gnt_idx_q;
    assign oBusValid = bus_valid_q;
    assign oBusy     = busy_q;
    assign oTimeout  = timeout_q;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Bench for tri_bus_arbiter: two instances (turnaround 1 and 3) share one request vector and are
// scored against a per-cycle reference of the round-robin/turnaround rules plus bus-safety invariants.
`timescale 1ns/1ps
module tb_tri_bus_arbiter;
    localparam int N      = 4;
    localparam int HOLD   = 4;
    localparam int TURN_A = 1;
    localparam int TURN_B = 3;

    typedef struct packed {
        logic [3:0] ena;
        logic [1:0] gnt;
        logic       valid;
        logic       busy;
        logic       tmo;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] ena_a, ena_b;
    logic [1:0] gnt_a, gnt_b;
    logic       val_a, val_b, busy_a, busy_b, tmo_a, tmo_b;

    int errors = 0;
    int checks = 0;

    // reference state: current owner (-1 none), zero-enable cycles still owed, rr pointer, cycles held
    int m_own [2];
    int m_gap [2];
    int m_ptr [2];
    int m_held[2];
    int turn_of[2];

    exp_t q_a[$];
    exp_t q_b[$];

    logic [3:0] prev_ena[2];
    int         zrun[2];
    bit         seen[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    tri_bus_arbiter #(.N_REQ(N), .TURN_CYCLES(TURN_A), .MAX_HOLD(HOLD)) dut_a (
        .iClk(clk), .iRst_n(rst_n), .iReq(req), .oEna(ena_a), .oGntIdx(gnt_a),
        .oBusValid(val_a), .oBusy(busy_a), .oTimeout(tmo_a));

    tri_bus_arbiter #(.N_REQ(N), .TURN_CYCLES(TURN_B), .MAX_HOLD(HOLD)) dut_b (
        .iClk(clk), .iRst_n(rst_n), .iReq(req), .oEna(ena_b), .oGntIdx(gnt_b),
        .oBusValid(val_b), .oBusy(busy_b), .oTimeout(tmo_b));

    task automatic chk(string name, int k, logic [7:0] got, logic [7:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s inst%0d @%0t: got %0h expected %0h", name, k, $time, got, expv);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k]  = -1;
            m_gap[k]  = 0;
            m_ptr[k]  = 0;
            m_held[k] = 0;
        end
    endfunction

    function automatic int pick(int k, logic [3:0] r);
        int c;
        for (int i = 0; i < N; i++) begin
            c = (m_ptr[k] + i) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // Outputs expected after the next rising edge, given the request vector sampled there
    function automatic exp_t model_step(int k, logic [3:0] r);
        exp_t e;
        bit   expired;
        int   w;
        expired = 1'b0;
        if (m_own[k] >= 0) begin
            m_held[k]++;
`ifdef ARB_TIMEOUT_EN
            expired = (m_held[k] >= HOLD) && r[m_own[k]];
`endif
            if (!r[m_own[k]] || expired) begin
                m_ptr[k] = (m_own[k] + 1) % N;
                m_own[k] = -1;
                m_gap[k] = turn_of[k];
            end
        end else if (m_gap[k] > 1) begin
            m_gap[k]--;
        end else begin
            w = pick(k, r);
            m_gap[k] = 0;
            if (w >= 0) begin
                m_own[k]  = w;
                m_held[k] = 0;
            end
        end
        e.ena   = (m_own[k] >= 0) ? 4'(1 << m_own[k]) : 4'b0000;
        e.gnt   = (m_own[k] >= 0) ? 2'(m_own[k]) : 2'b00;
        e.valid = (m_own[k] >= 0);
        e.busy  = (m_own[k] >= 0) || (m_gap[k] > 0);
        e.tmo   = expired;
        return e;
    endfunction

    task automatic step(logic [3:0] r);
        @(negedge clk);
        req = r;
        q_a.push_back(model_step(0, r));
        q_b.push_back(model_step(1, r));
    endtask

    task automatic score(int k, exp_t e, exp_t act);
        checks++;
        if (!e.valid) act.gnt = e.gnt;
        if (act !== e) begin
            errors++;
            $display("FAIL outputs inst%0d @%0t: got ena=%b gnt=%0d val=%b busy=%b tmo=%b expected ena=%b gnt=%0d val=%b busy=%b tmo=%b",
                     k, $time, act.ena, act.gnt, act.valid, act.busy, act.tmo,
                     e.ena, e.gnt, e.valid, e.busy, e.tmo);
        end
    endtask

    task automatic invariants(int k, logic [3:0] ena);
        chk("onehot", k, 8'($countones(ena) <= 1), 8'd1);
        if (ena != 4'b0000) begin
            if (prev_ena[k] != 4'b0000) chk("no_handover", k, ena, prev_ena[k]);
            else if (seen[k]) chk("turn_gap", k, 8'(zrun[k] >= turn_of[k]), 8'd1);
            seen[k] = 1'b1;
            zrun[k] = 0;
        end else begin
            zrun[k]++;
        end
        prev_ena[k] = ena;
    endtask

    // Monitor: pops one expectation per cycle, just after the rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                for (int k = 0; k < 2; k++) begin
                    prev_ena[k] = 4'b0000;
                    zrun[k]     = 0;
                    seen[k]     = 1'b0;
                end
            end else begin
                if (q_a.size() > 0) begin
                    e = q_a.pop_front();
                    score(0, e, {ena_a, gnt_a, val_a, busy_a, tmo_a});
                end
                if (q_b.size() > 0) begin
                    e = q_b.pop_front();
                    score(1, e, {ena_b, gnt_b, val_b, busy_b, tmo_b});
                end
                invariants(0, ena_a);
                invariants(1, ena_b);
            end
        end
    end

    task automatic chk_reset_state();
        chk("rst_ena", 0, 8'(ena_a), 8'h0);
        chk("rst_ena", 1, 8'(ena_b), 8'h0);
        chk("rst_flags", 0, 8'({gnt_a, val_a, busy_a, tmo_a}), 8'h0);
        chk("rst_flags", 1, 8'({gnt_b, val_b, busy_b, tmo_b}), 8'h0);
    endtask

    initial begin
        logic [3:0] r;
        turn_of[0] = TURN_A;
        turn_of[1] = TURN_B;
        model_reset();
        req   = 4'b0000;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state();
        rst_n = 1'b1;

        // single request, then drop
        repeat (5) step(4'b0100);
        repeat (4) step(4'b0000);

        // everyone requesting; the current owner of inst0 drops after 3 cycles and re-raises
        for (int c = 0; c < 40; c++) begin
            r = 4'b1111;
            if (m_own[0] >= 0 && m_held[0] >= 2) r[m_own[0]] = 1'b0;
            step(r);
        end
        repeat (6) step(4'b0000);

        // two contenders, owners handing over through the gap
        for (int c = 0; c < 30; c++) begin
            r = 4'b0011;
            if (m_own[0] >= 0 && m_held[0] >= 2) r[m_own[0]] = 1'b0;
            step(r);
        end
        repeat (6) step(4'b0000);

        // wrap-around of the rr pointer
        repeat (3) step(4'b0100);
        repeat (5) step(4'b0000);
        repeat (3) step(4'b0001);
        repeat (5) step(4'b0000);
        repeat (4) step(4'b1001);
        repeat (6) step(4'b0000);

        // held requests: forced rotation with the limit built, unbounded ownership without
        repeat (24) step(4'b0011);
        repeat (6) step(4'b0000);

        // asynchronous reset in the middle of a grant
        repeat (3) step(4'b0010);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ena", 0, 8'(ena_a), 8'h0);
        chk("async_rst_ena", 1, 8'(ena_b), 8'h0);
        q_a.delete();
        q_b.delete();
        model_reset();
        req = 4'b0000;
        repeat (2) @(negedge clk);
        chk_reset_state();
        rst_n = 1'b1;
        repeat (3) step(4'b0010);
        repeat (3) step(4'b1111);
        repeat (6) step(4'b0000);

        // randomized sticky requests
        r = 4'b0000;
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(3) == 0) r[b] = ~r[b];
            end
            step(r);
        end
        repeat (10) step(4'b0000);

        @(posedge clk);
        #2;
        chk("queue_drain", 0, 8'(q_a.size()), 8'h0);
        chk("queue_drain", 1, 8'(q_b.size()), 8'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tri_bus_arbiter.md
Name: tri_bus_arbiter

Overview:
Round-robin arbiter that generates the per-driver enables for a shared tri-state bus built from three_state_gates instances. Each requester owns one tri-state driver; this block drives that driver's iEna. It guarantees at most one enable is high at any time. It also inserts a turnaround gap between owners so two drivers never overlap on the bus.

Parameters:
N_REQ, 4, number of requesters / tri-state drivers (2..8)
TURN_CYCLES, 1, idle cycles with all enables low between successive grants (1..15)
MAX_HOLD, 16, max consecutive GRANT cycles per owner; used only with ARB_TIMEOUT_EN (1..255)

Ports:
iClk  input  1  system clock, rising-edge
iRst_n  input  1  asynchronous active-low reset
iReq  input  N_REQ  per-requester bus request, level, held while ownership is wanted
oEna  output  N_REQ  one-hot or zero; feeds iEna of each three_state_gates; 1 = drive bus
oGntIdx  output  clog2(N_REQ)  index of current owner; valid only when oBusValid=1
oBusValid  output  1  high while some oEna bit is high
oBusy  output  1  high whenever FSM is not IDLE
oTimeout  output  1  one-cycle pulse on forced release; tied 0 without ARB_TIMEOUT_EN

Behaviour:
- One clock domain. iRst_n is asynchronous and active-low; the reset assert is asynchronous and the release is synchronous to iClk.
- All outputs are registered.
- Reset values: oEna=0, oGntIdx=0, oBusValid=0, oBusy=0, oTimeout=0, rr pointer=0, FSM=IDLE, counters=0.
- FSM states: IDLE, GRANT, TURN.
- IDLE:
  - If iReq != 0, select the first set bit scanning upward from the rr pointer, wrapping modulo N_REQ.
  - Next edge: FSM moves to GRANT, oEna bit for the winner = 1, oGntIdx = winner, oBusValid=1, oBusy=1.
  - Latency from request to enable is 1 cycle.
- GRANT:
  - Ownership holds while iReq[oGntIdx]=1. Other requests are ignored; there is no preemption.
  - When iReq[oGntIdx]=0 is sampled, the next edge sets oEna=0 and oBusValid=0, FSM moves to TURN, and the rr pointer becomes (oGntIdx+1) mod N_REQ.
- TURN:
  - oEna stays 0 for exactly TURN_CYCLES cycles, counted from the first cycle with oEna=0.
  - On the last TURN cycle, arbitration is performed as in IDLE. If a winner exists, GRANT starts on the next edge; otherwise FSM returns to IDLE and oBusy=0.
- Contention rule: popcount(oEna) <= 1 in every cycle. Two different enable bits are never high in adjacent cycles; at least TURN_CYCLES zero cycles separate them.
- Same requester re-requesting: it still gets the TURN gap and waits its turn by rr order, which is a fairness guarantee.
- Requests that rise and fall while waiting in TURN or IDLE are only honoured if high at the arbitration sample.
- Reset mid-GRANT: oEna drops to 0 immediately (asynchronously) and all state clears.
- iReq bits whose index is >= N_REQ do not exist; the index arithmetic wraps modulo N_REQ, including when N_REQ is not a power of two.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A hold counter increments each GRANT cycle.
  - When it reaches MAX_HOLD while iReq[owner] is still 1, the block releases as if the request had dropped: oEna=0, FSM moves to TURN, and the rr pointer advances.
  - oTimeout pulses for 1 cycle with the oEna=0 edge. The counter clears on entering GRANT.
  - A still-requesting owner competes again normally after the TURN gap.
- Undefined: no counter is built, oTimeout is constant 0, and ownership is unbounded.

Test Plan:
1. Reset then single request (N_REQ=4, TURN_CYCLES=1): iReq=0100 at cycle 0 -> oEna=0100, oGntIdx=2, oBusValid=1 at cycle 1; drop iReq at cycle 5 -> oEna=0000 at cycle 6, oBusy=0 at cycle 7.
2. All requesting, iReq=1111 held, each owner drops after 3 cycles, then re-raises -> grant order 0,1,2,3,0; exactly 1 zero-enable cycle between each pair.
3. TURN_CYCLES=3, iReq=0011 -> owner 0, then oEna=0000 for 3 cycles, then owner 1; the checker asserts popcount(oEna)<=1 every cycle.
4. Wrap-around: pointer at 3 after owner 2 releases; iReq=0001 -> owner 0 granted via wrap; then iReq=1001 -> owner 3 granted next, before 0.
5. Async reset: iRst_n low mid-cycle during GRANT (oEna=0010) -> oEna=0000 before the next iClk edge; after release with iReq=0010 -> re-grant 1 cycle later and pointer restarts from 0.
6. ARB_TIMEOUT_EN defined, MAX_HOLD=4, iReq=0011 held -> owner 0 for 4 cycles, oTimeout=1 for one cycle, TURN, owner 1 for 4 cycles, then owner 0 again; undefined build -> owner 0 held indefinitely, oTimeout=0.
